// File: rtl/beat_judge_if.sv
// Handshake/bus bundle between the beat timer, key debouncers and the beat judge tracker.
// The master modport drives stimulus and chart writes; the slave modport is the tracker.
interface beat_judge_if #(
   parameter int LANES   = 4,
   parameter int BEAT_W  = 7,
   parameter int CNT_W   = 6,
   parameter int SCORE_W = 10
);
   logic               start;
   logic               loop_en;
   logic               beat_tick;
   logic [LANES-1:0]   key_press;
   logic               chart_we;
   logic [BEAT_W-1:0]  chart_addr;
   logic [LANES-1:0]   chart_data;
   logic [BEAT_W-1:0]  beat_cnt;
   logic [CNT_W-1:0]   note_idx;
   logic [LANES-1:0]   expect_lane;
   logic [SCORE_W-1:0] hit_cnt;
   logic [SCORE_W-1:0] miss_cnt;
   logic [SCORE_W-1:0] combo;
   logic [SCORE_W-1:0] score;
   logic               hit_pulse;
   logic               miss_pulse;
   logic               busy;
   logic               done;

   modport master (
      output start, loop_en, beat_tick, key_press, chart_we, chart_addr, chart_data,
      input  beat_cnt, note_idx, expect_lane, hit_cnt, miss_cnt, combo, score,
             hit_pulse, miss_pulse, busy, done
   );
   modport slave (
      input  start, loop_en, beat_tick, key_press, chart_we, chart_addr, chart_data,
      output beat_cnt, note_idx, expect_lane, hit_cnt, miss_cnt, combo, score,
             hit_pulse, miss_pulse, busy, done
   );
endinterface

// File: rtl/beat_judge_tracker.sv
// Writable per-lane note chart stepped on beat ticks; judges key presses per lane and keeps
// saturating hit/miss/combo/score counters for the display and score path.
module beat_judge_tracker #(
   parameter int LANES     = 4,
   parameter int BEAT_W    = 7,
   parameter int NUM_BEATS = 96,
   parameter int CNT_W     = 6,
   parameter int SCORE_W   = 10,
   parameter int BONUS_TH  = 8
) (
   input logic          clk,
   input logic          rst_n,
   beat_judge_if.slave  bus
);
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   // Chart is sized to the full address space so any beat address indexes it directly;
   // entries above NUM_BEATS are never written and stay zero.
   localparam int DEPTH = 2**BEAT_W;

   state_t             state_q, state_d;
   logic [LANES-1:0]   chart_q [DEPTH];
   logic [BEAT_W-1:0]  beat_q, beat_d, beat_nx;
   logic [CNT_W-1:0]   note_q, note_d;
   logic [LANES-1:0]   exp_q, exp_d, h, w, r, chart_nx;
   logic [SCORE_W-1:0] hit_q, hit_d, miss_q, miss_d, combo_q, combo_d, score_q, score_d;
   logic [SCORE_W-1:0] n_hit;
   logic               hit_p_q, hit_p_d, miss_p_q, miss_p_d;

   function automatic logic [SCORE_W-1:0] popcnt(input logic [LANES-1:0] v);
      logic [SCORE_W-1:0] c;
      c = '0;
      for (int i = 0; i < LANES; i++) c = c + SCORE_W'(v[i]);
      return c;
   endfunction

   function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                  input logic [SCORE_W-1:0] b);
      logic [SCORE_W:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[SCORE_W] ? '1 : s[SCORE_W-1:0];
   endfunction

   always_comb begin
      state_d  = state_q;
      beat_d   = beat_q;
      note_d   = note_q;
      exp_d    = exp_q;
      hit_d    = hit_q;
      miss_d   = miss_q;
      combo_d  = combo_q;
      score_d  = score_q;
      hit_p_d  = 1'b0;
      miss_p_d = 1'b0;
      h        = '0;
      w        = '0;
      r        = '0;
      n_hit    = '0;
      beat_nx  = beat_q + BEAT_W'(1);
      chart_nx = chart_q[beat_nx];
      case (state_q)
         S_IDLE, S_DONE: begin
            if (bus.start) begin
               state_d = S_RUN;
               beat_d  = '0;
               note_d  = '0;
               exp_d   = '0;
               hit_d   = '0;
               miss_d  = '0;
               combo_d = '0;
               score_d = '0;
            end
         end
         S_RUN: begin
            // Judge against the window as it stood at the start of the cycle.
            h        = bus.key_press & exp_q;
            w        = bus.key_press & ~exp_q;
            r        = exp_q & ~h;
            n_hit    = popcnt(h);
            hit_d    = sat_add(hit_q, n_hit);
            score_d  = sat_add(score_q, (combo_q >= SCORE_W'(BONUS_TH)) ? n_hit << 1 : n_hit);
            miss_d   = sat_add(miss_q, popcnt(w));
            combo_d  = (w != '0) ? '0 : sat_add(combo_q, n_hit);
            exp_d    = r;
            hit_p_d  = |h;
            miss_p_d = |w;
            if (bus.beat_tick) begin
               miss_d = sat_add(miss_d, popcnt(r));
               if (r != '0) begin
                  combo_d  = '0;
                  miss_p_d = 1'b1;
               end
               if (beat_q >= BEAT_W'(NUM_BEATS)) begin
                  if (bus.loop_en) begin
                     beat_d = BEAT_W'(1);
                     exp_d  = chart_q[1];
                     note_d = CNT_W'(|chart_q[1]);
                  end else begin
                     exp_d   = '0;
                     state_d = S_DONE;
                  end
               end else begin
                  beat_d = beat_nx;
                  exp_d  = chart_nx;
                  if (chart_nx != '0 && note_q != '1) note_d = note_q + CNT_W'(1);
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         beat_q   <= '0;
         note_q   <= '0;
         exp_q    <= '0;
         hit_q    <= '0;
         miss_q   <= '0;
         combo_q  <= '0;
         score_q  <= '0;
         hit_p_q  <= 1'b0;
         miss_p_q <= 1'b0;
         for (int i = 0; i < DEPTH; i++) chart_q[i] <= '0;
      end else begin
         state_q  <= state_d;
         beat_q   <= beat_d;
         note_q   <= note_d;
         exp_q    <= exp_d;
         hit_q    <= hit_d;
         miss_q   <= miss_d;
         combo_q  <= combo_d;
         score_q  <= score_d;
         hit_p_q  <= hit_p_d;
         miss_p_q <= miss_p_d;
         if (state_q == S_IDLE && bus.chart_we && bus.chart_addr != '0 &&
             bus.chart_addr <= BEAT_W'(NUM_BEATS))
            chart_q[bus.chart_addr] <= bus.chart_data;
      end
   end

   assign bus.beat_cnt    = beat_q;
   assign bus.note_idx    = note_q;
   assign bus.expect_lane = exp_q;
   assign bus.hit_cnt     = hit_q;
   assign bus.miss_cnt    = miss_q;
   assign bus.combo       = combo_q;
   assign bus.score       = score_q;
   assign bus.hit_pulse   = hit_p_q;
   assign bus.miss_pulse  = miss_p_q;
   assign bus.busy        = (state_q == S_RUN);
   assign bus.done        = (state_q == S_DONE);
endmodule

// File: tb/tb_beat_judge_tracker.sv
// Directed bench for beat_judge_tracker: expected outputs are queued with each step's stimulus
// and popped and compared one cycle later, once the registered outputs have updated.
module tb_beat_judge_tracker;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   beat_judge_if #(.LANES(4), .BEAT_W(7), .CNT_W(6), .SCORE_W(10)) bus ();

   beat_judge_tracker #(
      .LANES(4), .BEAT_W(7), .NUM_BEATS(3), .CNT_W(6), .SCORE_W(10), .BONUS_TH(8)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   typedef struct {
      string tag;
      int    val;
   } exp_t;
   exp_t exp_q[$];
   int   n_assert = 0;
   int   n_fail   = 0;

   function automatic int obs(input string tag);
      case (tag)
         "beat_cnt":    return int'(bus.beat_cnt);
         "note_idx":    return int'(bus.note_idx);
         "expect_lane": return int'(bus.expect_lane);
         "hit_cnt":     return int'(bus.hit_cnt);
         "miss_cnt":    return int'(bus.miss_cnt);
         "combo":       return int'(bus.combo);
         "score":       return int'(bus.score);
         "hit_pulse":   return int'(bus.hit_pulse);
         "miss_pulse":  return int'(bus.miss_pulse);
         "busy":        return int'(bus.busy);
         "done":        return int'(bus.done);
         default:       return -1;
      endcase
   endfunction

   task automatic ex(input int b, input int n, input int e, input int h, input int m,
                     input int c, input int s, input int hp, input int mp,
                     input int bz, input int dn);
      exp_q.push_back('{"beat_cnt", b});
      exp_q.push_back('{"note_idx", n});
      exp_q.push_back('{"expect_lane", e});
      exp_q.push_back('{"hit_cnt", h});
      exp_q.push_back('{"miss_cnt", m});
      exp_q.push_back('{"combo", c});
      exp_q.push_back('{"score", s});
      exp_q.push_back('{"hit_pulse", hp});
      exp_q.push_back('{"miss_pulse", mp});
      exp_q.push_back('{"busy", bz});
      exp_q.push_back('{"done", dn});
   endtask

   // Clock once, drop the pulse inputs, then drain the scoreboard against the DUT.
   task automatic cycle();
      exp_t e;
      int   got;
      @(posedge clk);
      #1;
      bus.start     = 1'b0;
      bus.beat_tick = 1'b0;
      bus.key_press = '0;
      bus.chart_we  = 1'b0;
      while (exp_q.size() > 0) begin
         e   = exp_q.pop_front();
         got = obs(e.tag);
         n_assert++;
         assert (got === e.val) else begin
            n_fail++;
            $error("FAIL %s observed %0d expected %0d", e.tag, got, e.val);
         end
      end
   endtask

   task automatic wr(input int addr, input logic [3:0] data);
      bus.chart_we   = 1'b1;
      bus.chart_addr = 7'(addr);
      bus.chart_data = data;
      cycle();
   endtask

   initial begin
      bus.start = 1'b0; bus.loop_en = 1'b0; bus.beat_tick = 1'b0; bus.key_press = '0;
      bus.chart_we = 1'b0; bus.chart_addr = '0; bus.chart_data = '0;
      rst_n = 1'b0;
      cycle();
      ex(0,0,0, 0,0,0,0, 0,0, 0,0); cycle();
      rst_n = 1'b1;
      wr(1, 4'b0001); wr(2, 4'b0000); wr(3, 4'b0110); wr(0, 4'b1111); wr(4, 4'b1111);

      // First run, loop_en = 0
      bus.start = 1'b1;                    ex(0,0,0,    0,0,0,0, 0,0, 1,0); cycle();
      bus.beat_tick = 1'b1;                ex(1,1,4'h1, 0,0,0,0, 0,0, 1,0); cycle();
      bus.key_press = 4'b1000;
      bus.chart_we = 1'b1; bus.chart_addr = 7'd2; bus.chart_data = 4'b1111;
                                           ex(1,1,4'h1, 0,1,0,0, 0,1, 1,0); cycle();
      bus.key_press = 4'b0001;             ex(1,1,4'h0, 1,1,1,1, 1,0, 1,0); cycle();
                                           ex(1,1,4'h0, 1,1,1,1, 0,0, 1,0); cycle();
      bus.beat_tick = 1'b1;                ex(2,1,4'h0, 1,1,1,1, 0,0, 1,0); cycle();
      bus.beat_tick = 1'b1;                ex(3,2,4'h6, 1,1,1,1, 0,0, 1,0); cycle();
      bus.key_press = 4'b0010;             ex(3,2,4'h4, 2,1,2,2, 1,0, 1,0); cycle();
      bus.beat_tick = 1'b1;                ex(3,2,4'h0, 2,2,0,2, 0,1, 0,1); cycle();
      bus.beat_tick = 1'b1; bus.key_press = 4'b0001;
                                           ex(3,2,4'h0, 2,2,0,2, 0,0, 0,1); cycle();

      // Second run from DONE, looping, building combo past the bonus threshold
      bus.loop_en = 1'b1;
      bus.start = 1'b1;                    ex(0,0,0,    0,0,0,0,  0,0, 1,0); cycle();
      bus.beat_tick = 1'b1;                ex(1,1,4'h1, 0,0,0,0,  0,0, 1,0); cycle();
      bus.key_press = 4'b0001;             ex(1,1,4'h0, 1,0,1,1,  1,0, 1,0); cycle();
      bus.beat_tick = 1'b1;                ex(2,1,4'h0, 1,0,1,1,  0,0, 1,0); cycle();
      bus.beat_tick = 1'b1;                ex(3,2,4'h6, 1,0,1,1,  0,0, 1,0); cycle();
      bus.key_press = 4'b0110;             ex(3,2,4'h0, 3,0,3,3,  1,0, 1,0); cycle();
      bus.beat_tick = 1'b1;                ex(1,1,4'h1, 3,0,3,3,  0,0, 1,0); cycle();
      bus.key_press = 4'b0001;             ex(1,1,4'h0, 4,0,4,4,  1,0, 1,0); cycle();
      bus.beat_tick = 1'b1;                ex(2,1,4'h0, 4,0,4,4,  0,0, 1,0); cycle();
      bus.beat_tick = 1'b1;                ex(3,2,4'h6, 4,0,4,4,  0,0, 1,0); cycle();
      bus.key_press = 4'b0110;             ex(3,2,4'h0, 6,0,6,6,  1,0, 1,0); cycle();
      bus.beat_tick = 1'b1;                ex(1,1,4'h1, 6,0,6,6,  0,0, 1,0); cycle();
      bus.key_press = 4'b0001;             ex(1,1,4'h0, 7,0,7,7,  1,0, 1,0); cycle();
      bus.beat_tick = 1'b1;                ex(2,1,4'h0, 7,0,7,7,  0,0, 1,0); cycle();
      bus.beat_tick = 1'b1;                ex(3,2,4'h6, 7,0,7,7,  0,0, 1,0); cycle();
      bus.key_press = 4'b0010;             ex(3,2,4'h4, 8,0,8,8,  1,0, 1,0); cycle();
      bus.key_press = 4'b0100;             ex(3,2,4'h0, 9,0,9,10, 1,0, 1,0); cycle();
      bus.beat_tick = 1'b1;                ex(1,1,4'h1, 9,0,9,10, 0,0, 1,0); cycle();
      bus.beat_tick = 1'b1; bus.key_press = 4'b0001;
                                           ex(2,1,4'h0, 10,0,10,12, 1,0, 1,0); cycle();

      // Reset mid-run clears outputs and the chart
      rst_n = 1'b0;                        ex(0,0,0, 0,0,0,0, 0,0, 0,0); cycle();
      rst_n = 1'b1;
      bus.start = 1'b1;                    ex(0,0,0, 0,0,0,0, 0,0, 1,0); cycle();
      bus.beat_tick = 1'b1;                ex(1,0,0, 0,0,0,0, 0,0, 1,0); cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
